// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef logic [3:0] digit_t;
  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 when the digit is 5 or more.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  digit_t d,
  output digit_t q
);
  always_comb q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-and-add-3 binary-to-BCD converter, one input bit per cycle.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
  output logic                  busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  if (pow10(DIGITS) <= (longint'(1) << WIDTH) - 1) begin : g_chk
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end
  state_t          state, nxt;
  logic [BW-1:0]   scr, adj, scr_nxt;
  logic [WIDTH-1:0] shr;
  logic [CW-1:0]   cnt;
  logic            unused_msb;
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (.d(scr[4*d +: 4]), .q(adj[4*d +: 4]));
  end
  // the adjusted top bit is shifted out; it is always 0 when DIGITS is sized correctly
  assign scr_nxt    = {adj[BW-2:0], shr[WIDTH-1]};
  assign unused_msb = adj[BW-1];
  always_comb begin
    nxt = state == IDLE  ? (in_valid ? SHIFT : IDLE) :
          state == SHIFT ? (cnt == CW'(1) ? DONE : SHIFT) : IDLE;
    in_ready  = state == IDLE;
    busy      = state != IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      scr <= '0;
      shr <= '0;
      cnt <= '0;
      bcd <= '0;
    end else if (state == IDLE && in_valid) begin
      shr <= in_data;
      scr <= '0;
      cnt <= CW'(WIDTH);
    end else if (state == SHIFT) begin
      scr <= scr_nxt;
      shr <= shr << 1;
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) bcd <= scr_nxt;
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: table vectors, back-to-back/held-valid streams, async reset abort and a full sweep.
module tb_bin2bcd_seq;
  localparam int WIDTH = 8;
  typedef struct {
    logic [7:0]  din;
    logic [11:0] exp;
  } vec_t;
  logic        clk = 0, rst = 1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 0;
  logic        in_ready, out_valid, busy;
  logic [11:0] bcd;
  logic [11:0] sb[$];
  logic [11:0] drv_exp = '0, last_bcd = '0, e;
  logic        use_ref = 0;
  int          m_cnt = 0, n_out = 0, passed = 0, total = 0, n0;
  vec_t        vecs[10];

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bcd(bcd), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a === x) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, x);
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // reference timing model: accept when idle, busy for WIDTH+1 cycles afterwards
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_cnt <= 0;
      sb.delete();
    end else if (m_cnt != 0) m_cnt <= m_cnt - 1;
    else if (in_valid) begin
      m_cnt <= WIDTH + 1;
      sb.push_back(use_ref ? ref_bcd(int'(in_data)) : drv_exp);
    end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(m_cnt == 0));
    chk("busy", 32'(busy), 32'(m_cnt != 0));
    chk("out_valid", 32'(out_valid), 32'(m_cnt == 1));
    if (!rst) last_bcd <= '0;
    else if (m_cnt == 1 && sb.size() != 0) begin
      e = sb.pop_front();
      n_out <= n_out + 1;
      chk("bcd", 32'(bcd), 32'(e));
      for (int i = 0; i < 3; i++) chk("digit_range", 32'(bcd[4*i +: 4] <= 4'd9), 32'(1));
      last_bcd <= e;
    end else chk("bcd_hold", 32'(bcd), 32'(last_bcd));
  end

  task automatic convert(input logic [7:0] v, input logic [11:0] x);
    @(negedge clk);
    while (m_cnt != 0) @(negedge clk);
    in_data = v;
    drv_exp = x;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    in_data = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || m_cnt != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    vecs[0] = '{8'd0,   12'h000}; vecs[1] = '{8'd255, 12'h255};
    vecs[2] = '{8'd99,  12'h099}; vecs[3] = '{8'd100, 12'h100};
    vecs[4] = '{8'd1,   12'h001}; vecs[5] = '{8'd9,   12'h009};
    vecs[6] = '{8'd10,  12'h010}; vecs[7] = '{8'd128, 12'h128};
    vecs[8] = '{8'd199, 12'h199}; vecs[9] = '{8'd250, 12'h250};
    #1 rst = 0;
    repeat (2) @(negedge clk);
    chk("rst_bcd", 32'(bcd), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    rst = 1;
    foreach (vecs[i]) begin
      convert(vecs[i].din, vecs[i].exp);
      drain();
    end
    // held-valid stream: only the value present at each idle accept is converted
    @(negedge clk);
    n0 = n_out;
    use_ref = 1;
    in_valid = 1;
    repeat (35) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 0;
    drain();
    use_ref = 0;
    chk("stream_results", 32'(n_out - n0), 32'(4));
    // asynchronous reset four cycles into a conversion
    convert(8'd200, 12'h200);
    repeat (3) @(posedge clk);
    #2 rst = 0;
    #1;
    chk("arst_bcd", 32'(bcd), 32'(0));
    chk("arst_out_valid", 32'(out_valid), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_in_ready", 32'(in_ready), 32'(1));
    repeat (2) @(negedge clk);
    rst = 1;
    convert(8'd37, 12'h037);
    drain();
    for (int v = 0; v < 256; v++) convert(8'(v), ref_bcd(v));
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
